// File: rtl/fractal_pixel_scheduler.sv
// Frame job sequencer: round-robin dispatch of 640x480 pixel jobs to iteration engines, raster-order retire.
// Optional frame cycle counter enabled by defining SCHED_PERF_CNT_EN.
module fractal_pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int ITER_W      = 8
) (
  input  logic                          out_stream_aclk,
  input  logic                          periph_resetn,
  input  logic                          enable,
  output logic [NUM_ENGINES-1:0]        eng_start_valid,
  input  logic [NUM_ENGINES-1:0]        eng_start_ready,
  output logic [15:0]                   eng_x,
  output logic [15:0]                   eng_y,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
  output logic [NUM_ENGINES-1:0]        eng_ack,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [ITER_W-1:0]             pix_iter,
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          frame_done,
  output logic [31:0]                   frame_cycles
);

  localparam int PW = $clog2(NUM_ENGINES);
  localparam logic [15:0] X_LAST = 16'(X_SIZE - 1);
  localparam logic [15:0] Y_LAST = 16'(Y_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [PW-1:0]          dptr, rptr;
  logic [15:0]            dx, dy, rx, ry;
  logic [NUM_ENGINES-1:0] busy;
  logic                   dispatch_ok, retire_ok, last_disp, last_ret;

  // Dispatch looks at registered busy, so an engine retiring this cycle is never re-offered until next cycle.
  always_comb begin
    eng_start_valid       = '0;
    eng_start_valid[dptr] = (state == RUN) && !busy[dptr];
  end

  assign dispatch_ok = eng_start_valid[dptr] & eng_start_ready[dptr];
  assign eng_x       = dx;
  assign eng_y       = dy;

  assign pix_valid = busy[rptr] & eng_done[rptr];
  assign retire_ok = pix_valid & pix_ready;
  // Gated by pix_valid so every output reads 0 while nothing is retiring.
  assign pix_iter  = pix_valid ? eng_iter[int'(rptr)*ITER_W +: ITER_W] : '0;
  assign pix_sof   = pix_valid && (rx == '0) && (ry == '0);
  assign pix_eol   = pix_valid && (rx == X_LAST);

  always_comb begin
    eng_ack       = '0;
    eng_ack[rptr] = retire_ok;
  end

  assign last_disp = dispatch_ok && (dx == X_LAST) && (dy == Y_LAST);
  assign last_ret  = retire_ok && (rx == X_LAST) && (ry == Y_LAST);

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state      <= IDLE;
      dptr       <= '0;
      rptr       <= '0;
      dx         <= '0;
      dy         <= '0;
      rx         <= '0;
      ry         <= '0;
      busy       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_ret;

      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (last_disp) state <= DRAIN;
        DRAIN:   if (last_ret) state <= enable ? RUN : IDLE;
        default: state <= IDLE;
      endcase

      if (dispatch_ok) begin
        busy[dptr] <= 1'b1;
        dptr       <= dptr + PW'(1);
        if (dx == X_LAST) begin
          dx <= '0;
          dy <= (dy == Y_LAST) ? '0 : dy + 16'd1;
        end else begin
          dx <= dx + 16'd1;
        end
      end

      if (retire_ok) begin
        busy[rptr] <= 1'b0;
        rptr       <= rptr + PW'(1);
        if (rx == X_LAST) begin
          rx <= '0;
          ry <= (ry == Y_LAST) ? '0 : ry + 16'd1;
        end else begin
          rx <= rx + 16'd1;
        end
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] perf_cnt;

  // Counter restarts on the frame's first accepted job; value at frame_done spans first accept to final retire.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      perf_cnt     <= '0;
      frame_cycles <= '0;
    end else begin
      if (dispatch_ok && (dx == '0) && (dy == '0))
        perf_cnt <= '0;
      else
        perf_cnt <= perf_cnt + 32'd1;
      if (frame_done)
        frame_cycles <= perf_cnt;
    end
  end
`else
  assign frame_cycles = '0;
`endif

endmodule

// File: tb/tb_fractal_pixel_scheduler.sv
// Scoreboard bench for fractal_pixel_scheduler on a 4x2 frame with 4 behavioural engines.
module tb_fractal_pixel_scheduler;

  localparam int NE   = 4;
  localparam int XS   = 4;
  localparam int YS   = 2;
  localparam int IW   = 8;
  localparam int NPIX = XS * YS;

  logic              clk = 1'b0;
  logic              periph_resetn = 1'b0;
  logic              enable = 1'b0;
  logic [NE-1:0]     eng_start_valid, eng_start_ready, eng_done, eng_ack;
  logic [15:0]       eng_x, eng_y;
  logic [NE*IW-1:0]  eng_iter;
  logic              pix_valid, pix_ready, pix_sof, pix_eol, frame_done;
  logic [IW-1:0]     pix_iter;
  logic [31:0]       frame_cycles;

  always #5 clk = ~clk;

  fractal_pixel_scheduler #(
    .NUM_ENGINES(NE),
    .X_SIZE     (XS),
    .Y_SIZE     (YS),
    .ITER_W     (IW)
  ) dut (
    .out_stream_aclk(clk),
    .periph_resetn  (periph_resetn),
    .enable         (enable),
    .eng_start_valid(eng_start_valid),
    .eng_start_ready(eng_start_ready),
    .eng_x          (eng_x),
    .eng_y          (eng_y),
    .eng_done       (eng_done),
    .eng_iter       (eng_iter),
    .eng_ack        (eng_ack),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_iter       (pix_iter),
    .pix_sof        (pix_sof),
    .pix_eol        (pix_eol),
    .frame_done     (frame_done),
    .frame_cycles   (frame_cycles)
  );

  typedef struct packed {
    logic [IW-1:0] iter;
    logic          sof;
    logic          eol;
  } pix_t;

  pix_t          exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [NE-1:0] m_bsy;
  int            m_cnt[NE];
  int            lat[NE];
  logic [IW-1:0] m_res[NE];
  int            d_idx, r_idx, d_ptr, r_ptr;
  int            first_acc, perf_exp;
  bit            fin_prev, fd_prev, held_v, spurious;
  logic [IW+1:0] held;
  int            stall_left;
  int            frames_done = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [IW-1:0] f_iter(input int x, input int y);
    return IW'(x * 37 + y * 11 + 3);
  endfunction

  task automatic drive();
    for (int k = 0; k < NE; k++) begin
      eng_done[k]          = (m_bsy[k] && m_cnt[k] == 0) || spurious;
      eng_iter[k*IW +: IW] = m_res[k];
    end
    eng_start_ready = ~m_bsy;
    pix_ready       = (stall_left == 0);
  endtask

  task automatic clear_model();
    m_bsy = '0;
    for (int k = 0; k < NE; k++) begin
      m_cnt[k] = 0;
      m_res[k] = '0;
    end
    exp_q.delete();
    d_idx = 0; r_idx = 0; d_ptr = 0; r_ptr = 0;
    held_v = 0; fin_prev = 0; fd_prev = 0; stall_left = 0; spurious = 0;
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic tick();
    logic [NE-1:0] acc, ack_m;
    logic          ret, fin, exp_pv;
    logic [15:0]   cx, cy;
    pix_t          exp_p;
    @(negedge clk);
    cyc++;
    acc = eng_start_valid & eng_start_ready;
    cx  = eng_x;
    cy  = eng_y;
    if (eng_start_valid != '0) begin
      check("start_onehot", eng_start_valid, NE'(1) << d_ptr);
      check("start_to_busy", eng_start_valid & m_bsy, 0);
      check("eng_x", eng_x, d_idx % XS);
      check("eng_y", eng_y, d_idx / XS);
    end
    if (acc != '0) begin
      exp_p.iter = f_iter(d_idx % XS, d_idx / XS);
      exp_p.sof  = (d_idx == 0);
      exp_p.eol  = ((d_idx % XS) == XS - 1);
      exp_q.push_back(exp_p);
      if (d_idx == 0) first_acc = cyc;
      d_idx = (d_idx + 1) % NPIX;
      d_ptr = (d_ptr + 1) % NE;
    end

    exp_pv = m_bsy[r_ptr] && (m_cnt[r_ptr] == 0);
    check("pix_valid", pix_valid, exp_pv);
    if (held_v) check("stall_stable", {pix_valid, pix_iter, pix_sof, pix_eol}, {1'b1, held});
    ret   = pix_valid && pix_ready;
    ack_m = '0;
    fin   = 1'b0;
    if (ret) begin
      check("pix_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_p = exp_q.pop_front();
        check("pix_iter", pix_iter, exp_p.iter);
        check("pix_sof", pix_sof, exp_p.sof);
        check("pix_eol", pix_eol, exp_p.eol);
      end
      check("eng_ack", eng_ack, NE'(1) << r_ptr);
      ack_m[r_ptr] = 1'b1;
      fin   = (r_idx == NPIX - 1);
      r_idx = (r_idx + 1) % NPIX;
      r_ptr = (r_ptr + 1) % NE;
    end else begin
      check("eng_ack_idle", eng_ack, 0);
    end

    check("frame_done", frame_done, fin_prev);
`ifdef SCHED_PERF_CNT_EN
    if (fd_prev) begin
      check("frame_cycles", frame_cycles, perf_exp);
      check("frame_cycles_nz", frame_cycles != 0, 1);
    end
`else
    if (fd_prev) check("frame_cycles_off", frame_cycles, 0);
`endif
    if (frame_done) frames_done++;
    if (fin) perf_exp = cyc - first_acc;
    held_v = pix_valid && !pix_ready;
    held   = {pix_iter, pix_sof, pix_eol};
    if (stall_left > 0 && pix_valid) stall_left--;
    fd_prev  = frame_done;
    fin_prev = fin;

    @(posedge clk);
    #1;
    for (int k = 0; k < NE; k++) begin
      if (ack_m[k]) m_bsy[k] = 1'b0;
      if (m_bsy[k] && m_cnt[k] > 0) m_cnt[k]--;
      if (acc[k]) begin
        m_bsy[k] = 1'b1;
        m_cnt[k] = lat[k];
        m_res[k] = f_iter(cx, cy);
      end
    end
    drive();
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 400) begin
      tick();
      n++;
    end
    check("frame_timeout", frames_done >= target, 1);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_no_start", eng_start_valid, 0);
    end
  endtask

  task automatic pulse_reset();
    #1 periph_resetn = 1'b0;
    #1;
    check("rst_outputs", {eng_start_valid, eng_ack, pix_valid, pix_iter, pix_sof, pix_eol,
                          frame_done, eng_x, eng_y}, 0);
    check("rst_frame_cycles", frame_cycles, 0);
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1 periph_resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    set_lat(3, 3, 3, 3);
    clear_model();
    drive();
    #3;
    check("rst_outputs", {eng_start_valid, eng_ack, pix_valid, pix_iter, pix_sof, pix_eol,
                          frame_done, eng_x, eng_y}, 0);
    check("rst_frame_cycles", frame_cycles, 0);
    @(posedge clk);
    #1 periph_resetn = 1'b1;
    idle_ticks(3);

    // Uniform latency, single frame then idle.
    enable = 1'b1;
    n = 0;
    while (d_idx < 1 && n < 20) begin tick(); n++; end
    check("first_dispatch_timeout", d_idx >= 1, 1);
    enable = 1'b0;
    wait_frames(1);
    idle_ticks(3);

    // Slow engine 0 holds back retirement; frames run back to back.
    set_lat(20, 2, 2, 2);
    enable = 1'b1;
    wait_frames(2);

    // Packer back-pressure for 10 valid cycles.
    set_lat(2, 2, 2, 2);
    stall_left = 10;
    drive();
    wait_frames(3);

    // enable dropped after pixel 2 dispatches: frame completes, then idle.
    n = 0;
    while (d_idx != 3 && n < 50) begin tick(); n++; end
    check("pixel2_timeout", d_idx, 3);
    enable = 1'b0;
    wait_frames(4);
    spurious = 1'b1;
    drive();
    idle_ticks(5);
    spurious = 1'b0;
    drive();

    // Reset mid-frame, then a clean frame from (0,0).
    enable = 1'b1;
    n = 0;
    while (r_idx != 5 && n < 100) begin tick(); n++; end
    check("pixel5_timeout", r_idx, 5);
    pulse_reset();
    wait_frames(5);

    // Latency 1 frame for the cycle counter.
    set_lat(1, 1, 1, 1);
    enable = 1'b0;
    wait_frames(6);
    idle_ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fractal_pixel_scheduler.md
Name: fractal_pixel_scheduler

Overview:
- Sequences one 640x480 frame of pixel jobs across NUM_ENGINES parallel Mandelbrot/Julia iteration engines.
- Dispatches pixel coordinates to engines in round-robin order and retires their iteration counts in strict raster order.
- Retired results feed the stream packer together with sof/eol markers.
- Sits between the AXI-Lite-configured iteration engines and the packer, in the out_stream_aclk domain.

Parameters:
- NUM_ENGINES, 4, number of iteration engines; power of two, 2..8.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- ITER_W, 8, iteration-count width.

Ports:
- out_stream_aclk  in  1  sole clock.
- periph_resetn  in  1  asynchronous, active-low reset.
- enable  in  1  run frames; sampled only at frame start.
- eng_start_valid  out  NUM_ENGINES  one-hot job offer to an engine.
- eng_start_ready  in  NUM_ENGINES  engine idle, accepts job.
- eng_x  out  16  job x coordinate; shared bus.
- eng_y  out  16  job y coordinate; shared bus.
- eng_done  in  NUM_ENGINES  engine holds a finished result.
- eng_iter  in  NUM_ENGINES*ITER_W  per-engine iteration count; engine k occupies slice [k*ITER_W +: ITER_W].
- eng_ack  out  NUM_ENGINES  one-hot result consumed; engine drops eng_done next cycle.
- pix_valid  out  1  result available to packer.
- pix_ready  in  1  packer ready.
- pix_iter  out  ITER_W  iteration count of retired pixel.
- pix_sof  out  1  retired pixel is (0,0).
- pix_eol  out  1  retired pixel has x = X_SIZE-1.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame retires.
- frame_cycles  out  32  performance count; see Optional Feature.

Behaviour:
- Reset (async assert, sync release) clears: state=IDLE; dptr=rptr=0; dispatch counters dx=dy=0; retire counters rx=ry=0; busy[]=0; frame_done=0. All outputs read 0.
- State machine:
  - IDLE: if enable, go to RUN.
  - RUN: dispatch jobs. When the pixel (X_SIZE-1, Y_SIZE-1) is accepted, go to DRAIN.
  - DRAIN: no dispatch. When the final pixel retires, pulse frame_done on the next cycle. Go to RUN if enable is high at that point, else IDLE. Dispatch counters wrap to 0.
- Dispatch (RUN only):
  - eng_start_valid[dptr] = !busy[dptr]; all other bits 0.
  - eng_x/eng_y = dx/dy, combinational from registers.
  - Acceptance = valid & eng_start_ready[dptr]. On acceptance: busy[dptr] set, dptr++ mod NUM_ENGINES, and dx/dy advance in raster order (x wraps at X_SIZE-1, then y increments).
  - At most one dispatch per cycle.
- Retire:
  - pix_valid = busy[rptr] & eng_done[rptr].
  - pix_iter = eng_iter slice rptr. pix_sof = (rx==0 && ry==0). pix_eol = (rx==X_SIZE-1).
  - eng_ack[rptr] = pix_valid & pix_ready, combinational.
  - On handshake: busy[rptr] cleared, rptr++ mod NUM_ENGINES, and rx/ry advance in raster order.
  - eng_done on a non-busy engine is ignored.
- Ordering: dptr and rptr both advance round-robin, so retirement is raster order. At most NUM_ENGINES jobs are outstanding.
- Same-cycle dispatch and retire are allowed on different engines. The same engine cannot be dispatched and retired in one cycle because dispatch checks registered busy.
- pix_valid must not drop without a handshake. Once asserted, pix_iter, pix_sof and pix_eol stay stable until pix_ready.
- enable low mid-frame has no effect until the frame completes.
- Reset mid-frame aborts all jobs. The next frame restarts at (0,0) with sof.

Optional Feature:
- Macro SCHED_PERF_CNT_EN.
- Defined: a 32-bit counter clears on the cycle the frame's first dispatch is accepted and increments every cycle until the final retire. The count is latched to frame_cycles in the cycle frame_done pulses.
- Not defined: no counter logic; frame_cycles is tied to 0.

Test Plan (bench overrides X_SIZE=4, Y_SIZE=2, NUM_ENGINES=4):
- Engines done 3 cycles after start, pix_ready=1 -> 8 pixels retire in order (0,0)..(3,1). sof only on pixel 0; eol on pixels 3 and 7; frame_done one pulse 1 cycle after pixel 7.
- Engine 0 latency 20 cycles, others 2 -> no pix_valid until engine 0 is done. Retire order is still engine 0,1,2,3. At most 4 jobs outstanding; no eng_start_valid to a busy engine.
- pix_ready held 0 for 10 cycles with pix_valid=1 -> pix_iter, pix_sof and pix_eol stay stable. eng_ack stays 0 until pix_ready rises.
- enable dropped at pixel 2, held low -> the frame completes all 8 pixels, then the block returns to IDLE and eng_start_valid stays 0.
- periph_resetn pulsed low at pixel 5 -> all outputs 0 immediately. After release with enable=1, the first retired pixel has sof=1 and coordinates (0,0).
- SCHED_PERF_CNT_EN defined, engine latency 1 and pix_ready=1 -> frame_cycles nonzero and equal to the bench-measured first-accept-to-last-retire cycle count. Undefined -> frame_cycles=0.
